// File: rtl/pool_pkg.sv
// Shared types and window-slot names for the 2x2 pooling path.
// The slot constants are used both when gathering a window and when
// the pooling stage reduces it, so both sides agree on the layout.
package pool_pkg;

   // One channel value of one pixel.
   typedef logic signed [15:0] pixel_t;

   // Pixels per non-overlapping 2x2 window.
   localparam int WIN_SIZE = 4;

   // Slot positions inside a window, in raster order.
   localparam int TL = 0;
   localparam int TR = 1;
   localparam int BL = 2;
   localparam int BR = 3;

endpackage

// File: rtl/pool_line_buffer.sv
// One image row of pixel storage for the window gatherer.
// Single synchronous write port and two combinational read ports, so an
// odd-row pixel can see both upper neighbours of its window in the same
// cycle it arrives. Contents are not reset; they are always rewritten on
// an even row before an odd row reads them.
module pool_line_buffer
   import pool_pkg::*;
#(
   parameter int FM_DEPTH = 64,
   parameter int IMG_W    = 32,
   parameter int AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  pixel_t        wr_data   [FM_DEPTH],
   input  logic [AW-1:0] rd_addr_a,
   output pixel_t        rd_data_a [FM_DEPTH],
   input  logic [AW-1:0] rd_addr_b,
   output pixel_t        rd_data_b [FM_DEPTH]
);

   pixel_t mem [IMG_W][FM_DEPTH];

   // Store a whole pixel (all channels) at its column.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Combinational reads keep the gather latency at a single register.
   always_comb begin
      rd_data_a = mem[rd_addr_a];
      rd_data_b = mem[rd_addr_b];
   end

endmodule

// File: rtl/pool_window_gather.sv
// Collects a raster pixel stream into non-overlapping 2x2 windows.
//
// Interface semantics: there is no backpressure in this path. A pixel is
// accepted on every rising clk edge where data_in_valid is high. A window
// is presented for exactly one cycle with window_valid high; window_out
// holds its last value otherwise and must only be sampled when
// window_valid is high. frame_done pulses together with the final window
// of a frame.
//
// Even rows are written into the line buffer. On odd rows the even-column
// pixel is held in a left-pixel register, and the odd-column pixel closes
// the window using the two buffered upper pixels.
module pool_window_gather
   import pool_pkg::*;
#(
   parameter int FM_DEPTH = 64,
   parameter int IMG_W    = 32,
   parameter int IMG_H    = 32
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   data_in_valid,
   input  pixel_t data_in    [FM_DEPTH],
   output logic   window_valid,
   output pixel_t window_out [FM_DEPTH][WIN_SIZE],
   output logic   frame_done
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0] col_cnt;
   logic [RW-1:0] row_cnt;
   pixel_t        left_pix [FM_DEPTH];

   // Line buffer hookup.
   logic          lb_wr_en;
   logic [CW-1:0] lb_addr_left;
   pixel_t        lb_upper_left  [FM_DEPTH];
   pixel_t        lb_upper_right [FM_DEPTH];

   // Position decode for the pixel currently on data_in.
   logic odd_row;
   logic odd_col;
   logic last_col;
   logic last_row;

   // Decode where the incoming pixel lands in the frame.
   always_comb begin
      odd_row      = row_cnt[0];
      odd_col      = col_cnt[0];
      last_col     = (col_cnt == COL_LAST);
      last_row     = (row_cnt == ROW_LAST);
      lb_wr_en     = data_in_valid & ~row_cnt[0];
      // Only used on odd columns, where col-1 is col with bit 0 cleared.
      lb_addr_left = {col_cnt[CW-1:1], 1'b0};
   end

   pool_line_buffer #(
      .FM_DEPTH (FM_DEPTH),
      .IMG_W    (IMG_W),
      .AW       (CW)
   ) u_line_buffer (
      .clk       (clk),
      .wr_en     (lb_wr_en),
      .wr_addr   (col_cnt),
      .wr_data   (data_in),
      .rd_addr_a (lb_addr_left),
      .rd_data_a (lb_upper_left),
      .rd_addr_b (col_cnt),
      .rd_data_b (lb_upper_right)
   );

   // Raster position counters; advance only on accepted pixels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (data_in_valid) begin
         if (last_col) begin
            col_cnt <= '0;
            row_cnt <= last_row ? '0 : row_cnt + RW'(1);
         end else begin
            col_cnt <= col_cnt + CW'(1);
         end
      end
   end

   // Hold the bottom-left pixel of the window being built.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < FM_DEPTH; c++) begin
            left_pix[c] <= '0;
         end
      end else if (data_in_valid && odd_row && !odd_col) begin
         left_pix <= data_in;
      end
   end

   // Register a completed window and its strobes one cycle after the
   // bottom-right pixel is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         window_valid <= 1'b0;
         frame_done   <= 1'b0;
         for (int c = 0; c < FM_DEPTH; c++) begin
            for (int k = 0; k < WIN_SIZE; k++) begin
               window_out[c][k] <= '0;
            end
         end
      end else begin
         window_valid <= 1'b0;
         frame_done   <= 1'b0;
         if (data_in_valid && odd_row && odd_col) begin
            window_valid <= 1'b1;
            frame_done   <= last_col & last_row;
            for (int c = 0; c < FM_DEPTH; c++) begin
               window_out[c][TL] <= lb_upper_left[c];
               window_out[c][TR] <= lb_upper_right[c];
               window_out[c][BL] <= left_pix[c];
               window_out[c][BR] <= data_in[c];
            end
         end
      end
   end

endmodule

// File: tb/tb_pool_window_gather.sv
// Scoreboard bench for pool_window_gather with a 4x4 frame of 2 channels.
// The driver pushes the expected window (from its own copy of the image)
// and the cycle it must appear in; a monitor pops and compares on every
// window_valid.
module tb_pool_window_gather;
   import pool_pkg::*;

   localparam int FMD = 2;
   localparam int W   = 4;
   localparam int H   = 4;
   localparam int PW  = FMD * WIN_SIZE * 16 + 1;

   logic   clk;
   logic   rst;
   logic   data_in_valid;
   pixel_t data_in    [FMD];
   logic   window_valid;
   pixel_t window_out [FMD][WIN_SIZE];
   logic   frame_done;

   pool_window_gather #(
      .FM_DEPTH (FMD),
      .IMG_W    (W),
      .IMG_H    (H)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .data_in_valid (data_in_valid),
      .data_in       (data_in),
      .window_valid  (window_valid),
      .window_out    (window_out),
      .frame_done    (frame_done)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [PW-1:0] exp_q[$];
   int            exp_cyc_q[$];
   logic [PW-1:0] win_log[$];
   int            checks = 0;
   int            errors = 0;

   pixel_t img [H][W][FMD];

   function automatic logic [PW-1:0] pack_exp(input int r, input int c);
      logic [PW-1:0] v;
      v = '0;
      for (int ch = 0; ch < FMD; ch++) begin
         v[(ch*4+TL)*16 +: 16] = img[r-1][c-1][ch];
         v[(ch*4+TR)*16 +: 16] = img[r-1][c][ch];
         v[(ch*4+BL)*16 +: 16] = img[r][c-1][ch];
         v[(ch*4+BR)*16 +: 16] = img[r][c][ch];
      end
      v[PW-1] = (r == H-1) && (c == W-1);
      return v;
   endfunction

   function automatic logic [PW-1:0] pack_act();
      logic [PW-1:0] v;
      v = '0;
      for (int ch = 0; ch < FMD; ch++) begin
         for (int k = 0; k < WIN_SIZE; k++) begin
            v[(ch*4+k)*16 +: 16] = window_out[ch][k];
         end
      end
      v[PW-1] = frame_done;
      return v;
   endfunction

   // Ramp image: ch0 = base + row*16 + col, ch1 = its negation.
   task automatic load_ramp(input int base);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            img[r][c][0] = pixel_t'(base + r*16 + c);
            img[r][c][1] = pixel_t'(-(base + r*16 + c));
         end
      end
   endtask

   // Extreme image: ch0 alternates 32767 / -32768 in raster order.
   task automatic load_extreme();
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            img[r][c][0] = ((r*W + c) % 2 == 0) ? 16'sh7FFF : 16'sh8000;
            img[r][c][1] = pixel_t'(-(r*16 + c));
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_cycle();
      @(posedge clk);
      #1;
      data_in_valid = 1'b0;
      for (int ch = 0; ch < FMD; ch++) data_in[ch] = pixel_t'($urandom);
   endtask

   task automatic drive_pixel(input int r, input int c);
      @(posedge clk);
      #1;
      data_in_valid = 1'b1;
      for (int ch = 0; ch < FMD; ch++) data_in[ch] = img[r][c][ch];
      if ((r % 2 == 1) && (c % 2 == 1)) begin
         exp_q.push_back(pack_exp(r, c));
         exp_cyc_q.push_back(cyc + 1);
      end
   endtask

   task automatic send_frame(input bit gaps);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (gaps) repeat ($urandom_range(0, 1)) idle_cycle();
            drive_pixel(r, c);
         end
      end
   endtask

   task automatic drain();
      idle_cycle();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d windows outstanding, required 0", exp_q.size());
         exp_q.delete();
         exp_cyc_q.delete();
      end
   endtask

   // Hand-computed check of one channel of a logged window.
   task automatic check_ch(input string name, input int idx, input int ch,
                           input int e0, input int e1, input int e2, input int e3);
      logic [PW-1:0] w;
      pixel_t got [4];
      pixel_t req [4];
      req[0] = pixel_t'(e0); req[1] = pixel_t'(e1);
      req[2] = pixel_t'(e2); req[3] = pixel_t'(e3);
      checks++;
      if (idx >= win_log.size()) begin
         errors++;
         $display("FAIL %s: window %0d never seen (%0d logged)", name, idx, win_log.size());
         return;
      end
      w = win_log[idx];
      for (int k = 0; k < 4; k++) got[k] = w[(ch*4+k)*16 +: 16];
      if (got != req) begin
         errors++;
         $display("FAIL %s: got {%0d,%0d,%0d,%0d} required {%0d,%0d,%0d,%0d}", name,
                  got[0], got[1], got[2], got[3], req[0], req[1], req[2], req[3]);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b required %b", name, act, req);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if (window_valid !== 1'b0 || frame_done !== 1'b0 || pack_act() !== '0) begin
         errors++;
         $display("FAIL %s: valid=%b done=%b win=%h required all zero",
                  name, window_valid, frame_done, pack_act());
      end
   endtask

   // ---------------- monitor ----------------
   task automatic monitor_loop();
      logic [PW-1:0] act;
      forever begin
         @(negedge clk);
         if (frame_done && !window_valid) begin
            checks++;
            errors++;
            $display("FAIL done_without_valid: cycle %0d", cyc);
         end
         if (window_valid) begin
            act = pack_act();
            win_log.push_back(act);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_window: cycle %0d got %h", cyc, act);
            end else begin
               logic [PW-1:0] e;
               int            ec;
               e  = exp_q.pop_front();
               ec = exp_cyc_q.pop_front();
               if (act !== e) begin
                  errors++;
                  $display("FAIL window_data: got %h required %h", act, e);
               end
               checks++;
               if (cyc != ec) begin
                  errors++;
                  $display("FAIL window_latency: got cycle %0d required %0d", cyc, ec);
               end
            end
         end else if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
            checks++;
            errors++;
            $display("FAIL missing_window: required at cycle %0d, now %0d", exp_cyc_q[0], cyc);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst           = 1'b1;
      data_in_valid = 1'b0;
      for (int ch = 0; ch < FMD; ch++) data_in[ch] = '0;
      fork
         monitor_loop();
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset_state");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single frame, continuous valid.
      load_ramp(0);
      win_log.delete();
      send_frame(1'b0);
      drain();
      check_ch("single_first_ch0", 0, 0, 0, 1, 16, 17);
      check_ch("single_first_ch1", 0, 1, 0, -1, -16, -17);
      check_ch("single_last_ch0", 3, 0, 34, 35, 50, 51);
      check_bit("single_first_not_done", win_log.size() > 0 ? win_log[0][PW-1] : 1'bx, 1'b0);
      check_bit("single_last_done", win_log.size() > 3 ? win_log[3][PW-1] : 1'bx, 1'b1);

      // Same frame with random idle gaps.
      win_log.delete();
      send_frame(1'b1);
      drain();
      check_ch("gaps_first_ch0", 0, 0, 0, 1, 16, 17);
      check_ch("gaps_last_ch0", 3, 0, 34, 35, 50, 51);

      // Two frames back to back, second offset by 100.
      win_log.delete();
      send_frame(1'b0);
      load_ramp(100);
      send_frame(1'b0);
      drain();
      check_ch("frame2_first_ch0", 4, 0, 100, 101, 116, 117);
      check_ch("frame2_first_ch1", 4, 1, -100, -101, -116, -117);
      check_ch("frame2_last_ch0", 7, 0, 134, 135, 150, 151);

      // Reset after 9 pixels, then a full frame.
      load_ramp(0);
      for (int i = 0; i < 9; i++) drive_pixel(i / W, i % W);
      @(posedge clk);
      #1;
      rst           = 1'b1;
      data_in_valid = 1'b0;
      @(negedge clk);
      check_outputs_zero("mid_reset_a");
      @(negedge clk);
      check_outputs_zero("mid_reset_b");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_bit("post_reset_no_valid", window_valid, 1'b0);
      win_log.delete();
      send_frame(1'b0);
      drain();
      check_ch("after_reset_first_ch0", 0, 0, 0, 1, 16, 17);
      check_ch("after_reset_last_ch0", 3, 0, 34, 35, 50, 51);

      // Extreme signed values.
      load_extreme();
      win_log.delete();
      send_frame(1'b1);
      drain();
      check_ch("extreme_first_ch0", 0, 0, 32767, -32768, 32767, -32768);
      check_ch("extreme_last_ch0", 3, 0, 32767, -32768, 32767, -32768);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case something never returns.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
